// File: rtl/cpu_clken_gen.sv
// Master-clock divider for the 6502 core: generates the cpu_clken strobe, Phi2,
// a stretched CPU reset, and wait-state stretching with a timeout guard.
module cpu_clken_gen #(
    parameter int DIV        = 4,
    parameter int RST_CYCLES = 8,
    parameter int WAIT_MAX   = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wait_req,
    output logic       Phi2,
    output logic       cpu_clken,
    output logic       cpu_rst_n,
    output logic       wait_timeout,
    output logic [3:0] phase
);

    localparam logic [3:0] LAST      = 4'(DIV - 1);
    localparam logic [3:0] HALF      = 4'(DIV / 2);
    localparam logic [7:0] RST_LAST  = 8'(RST_CYCLES);
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX);

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] rst_cnt, rst_cnt_nxt;
    logic [7:0] stall_cnt, stall_cnt_nxt;
    logic [3:0] stall_tick, stall_tick_nxt;
    logic [3:0] phase_nxt;
    logic       cpu_rst_n_nxt, wait_timeout_nxt;
    logic       eoc, tick_last;

    assign eoc       = (phase == LAST);
    assign tick_last = (stall_tick == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= HOLD;
            phase        <= 4'd0;
            Phi2         <= 1'b0;
            rst_cnt      <= 8'd0;
            stall_cnt    <= 8'd0;
            stall_tick   <= 4'd0;
            cpu_rst_n    <= 1'b0;
            wait_timeout <= 1'b0;
        end else begin
            state        <= state_nxt;
            phase        <= phase_nxt;
            Phi2         <= (phase_nxt >= HALF);
            rst_cnt      <= rst_cnt_nxt;
            stall_cnt    <= stall_cnt_nxt;
            stall_tick   <= stall_tick_nxt;
            cpu_rst_n    <= cpu_rst_n_nxt;
            wait_timeout <= wait_timeout_nxt;
        end
    end

    // cpu_clken is combinational so the strobe can be withheld in the very
    // cycle wait_req is seen at the end-of-cycle point.
    always_comb begin
        state_nxt        = state;
        phase_nxt        = eoc ? 4'd0 : phase + 4'd1;
        rst_cnt_nxt      = rst_cnt;
        stall_cnt_nxt    = stall_cnt;
        stall_tick_nxt   = stall_tick;
        cpu_rst_n_nxt    = cpu_rst_n;
        wait_timeout_nxt = wait_timeout;
        cpu_clken        = 1'b0;
        case (state)
            HOLD: begin
                if (eoc) begin
                    cpu_clken   = 1'b1;
                    rst_cnt_nxt = rst_cnt + 8'd1;
                    if (rst_cnt + 8'd1 == RST_LAST) begin
                        state_nxt     = RUN;
                        cpu_rst_n_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                if (eoc) begin
                    if (wait_req) begin
                        state_nxt      = STALL;
                        stall_cnt_nxt  = 8'd1;
                        stall_tick_nxt = 4'd0;
                        phase_nxt      = LAST;
                    end else begin
                        cpu_clken = 1'b1;
                    end
                end
            end
            STALL: begin
                // Phase is frozen; stall_tick measures each stalled CPU cycle.
                phase_nxt = LAST;
                if (tick_last) begin
                    if (!wait_req || stall_cnt == WAIT_LAST) begin
                        cpu_clken = 1'b1;
                        phase_nxt = 4'd0;
                        state_nxt = RUN;
                        if (wait_req) begin
                            wait_timeout_nxt = 1'b1;
                        end
                    end else begin
                        stall_cnt_nxt  = stall_cnt + 8'd1;
                        stall_tick_nxt = 4'd0;
                    end
                end else begin
                    stall_tick_nxt = stall_tick + 4'd1;
                end
            end
            default: begin
                state_nxt = HOLD;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_clken_gen.sv
// Bench for cpu_clken_gen: three instances (DIV=4/WAIT_MAX=15, DIV=4/WAIT_MAX=3,
// DIV=2) share one stimulus; each test phase checks one instance cycle by cycle.
module tb_cpu_clken_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wait_req = 1'b0;

    logic       phi2_a, ce_a, crn_a, to_a;
    logic [3:0] phase_a;
    logic       phi2_b, ce_b, crn_b, to_b;
    logic [3:0] phase_b;
    logic       phi2_c, ce_c, crn_c, to_c;
    logic [3:0] phase_c;

    cpu_clken_gen #(.DIV(4), .RST_CYCLES(8), .WAIT_MAX(15)) dut_main (
        .clk(clk), .rst_n(rst_n), .wait_req(wait_req),
        .Phi2(phi2_a), .cpu_clken(ce_a), .cpu_rst_n(crn_a),
        .wait_timeout(to_a), .phase(phase_a)
    );

    cpu_clken_gen #(.DIV(4), .RST_CYCLES(8), .WAIT_MAX(3)) dut_to (
        .clk(clk), .rst_n(rst_n), .wait_req(wait_req),
        .Phi2(phi2_b), .cpu_clken(ce_b), .cpu_rst_n(crn_b),
        .wait_timeout(to_b), .phase(phase_b)
    );

    cpu_clken_gen #(.DIV(2), .RST_CYCLES(8), .WAIT_MAX(15)) dut_div2 (
        .clk(clk), .rst_n(rst_n), .wait_req(wait_req),
        .Phi2(phi2_c), .cpu_clken(ce_c), .cpu_rst_n(crn_c),
        .wait_timeout(to_c), .phase(phase_c)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary by 100000 ns");
        $fatal(1);
    end

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic       wr;
        logic [7:0] exp;
    } vec_t;

    vec_t tab4[40];
    vec_t tab2[24];

    // Packed view: {phase[3:0], Phi2, cpu_clken, cpu_rst_n, wait_timeout}
    function automatic logic [7:0] mk(input int ph, input logic p2, input logic ce,
                                      input logic rn, input logic to);
        return {4'(ph), p2, ce, rn, to};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got phase=%0d phi2=%b clken=%b rst_n=%b timeout=%b, expected phase=%0d phi2=%b clken=%b rst_n=%b timeout=%b",
                     name, act[7:4], act[3], act[2], act[1], act[0],
                     exp[7:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic sample(input int sel, output logic [7:0] v);
        case (sel)
            0:       v = {phase_a, phi2_a, ce_a, crn_a, to_a};
            1:       v = {phase_b, phi2_b, ce_b, crn_b, to_b};
            default: v = {phase_c, phi2_c, ce_c, crn_c, to_c};
        endcase
    endtask

    // One CPU-clock cycle: drive at negedge, sample 1 ns later, score via queue.
    task automatic cyc(input int sel, input logic wr, input logic [7:0] exp, input string name);
        logic [7:0] act;
        logic [7:0] e;
        @(negedge clk);
        wait_req = wr;
        exp_q.push_back(exp);
        #1;
        sample(sel, act);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %b", name, act);
        end else begin
            e = exp_q.pop_front();
            check(name, act, e);
        end
    endtask

    // Asynchronous assertion mid-cycle, immediate check, then release away from the edge.
    task automatic do_reset(input string tag);
        logic [7:0] v;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        wait_req = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            sample(s, v);
            check($sformatf("%s_reset_inst%0d", tag, s), v, 8'h00);
        end
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic fill_tabs();
        for (int k = 1; k <= 40; k++) begin
            int ph;
            ph = (k - 1) % 4;
            tab4[k-1].exp = mk(ph, ph >= 2, ph == 3, k >= 33, 1'b0);
            if (k <= 32 || ph != 3) tab4[k-1].wr = 1'($urandom_range(0, 1));
            else                    tab4[k-1].wr = 1'b0;
        end
        for (int k = 1; k <= 24; k++) begin
            int ph;
            ph = (k - 1) % 2;
            tab2[k-1].exp = mk(ph, ph >= 1, ph == 1, k >= 17, 1'b0);
            if (k <= 16 || ph != 1) tab2[k-1].wr = 1'($urandom_range(0, 1));
            else                    tab2[k-1].wr = 1'b0;
        end
    endtask

    task automatic run_tab4(input int sel, input string tag);
        for (int k = 0; k < 40; k++)
            cyc(sel, tab4[k].wr, tab4[k].exp, $sformatf("%s_tab4[%0d]", tag, k + 1));
    endtask

    initial begin
        fill_tabs();

        // Reset state and HOLD sequence with random wait_req (ignored in HOLD)
        do_reset("init");
        run_tab4(0, "main");

        // Single wait state: strobes at cycles 40 and 48, phase frozen at 3
        for (int k = 41; k <= 43; k++)
            cyc(0, 1'($urandom_range(0, 1)), mk(k - 41, (k - 41) >= 2, 1'b0, 1'b1, 1'b0), "ws_run");
        cyc(0, 1'b1, mk(3, 1'b1, 1'b0, 1'b1, 1'b0), "ws_enter");
        for (int k = 45; k <= 47; k++)
            cyc(0, 1'($urandom_range(0, 1)), mk(3, 1'b1, 1'b0, 1'b1, 1'b0), "ws_stall");
        cyc(0, 1'b0, mk(3, 1'b1, 1'b1, 1'b1, 1'b0), "ws_release");
        cyc(0, 1'b0, mk(0, 1'b0, 1'b0, 1'b1, 1'b0), "ws_after");

        // Timeout with WAIT_MAX=3: forced strobe 16 clks after the one at cycle 40
        do_reset("to");
        run_tab4(1, "to");
        for (int k = 41; k <= 43; k++)
            cyc(1, 1'b0, mk(k - 41, (k - 41) >= 2, 1'b0, 1'b1, 1'b0), "to_run");
        cyc(1, 1'b1, mk(3, 1'b1, 1'b0, 1'b1, 1'b0), "to_enter");
        for (int k = 45; k <= 55; k++)
            cyc(1, 1'b1, mk(3, 1'b1, 1'b0, 1'b1, 1'b0), $sformatf("to_stall[%0d]", k));
        cyc(1, 1'b1, mk(3, 1'b1, 1'b1, 1'b1, 1'b0), "to_forced");
        for (int k = 57; k <= 64; k++) begin
            int ph;
            ph = (k - 1) % 4;
            cyc(1, (ph == 3) ? 1'b0 : 1'(k % 2), mk(ph, ph >= 2, ph == 3, 1'b1, 1'b1),
                $sformatf("to_sticky[%0d]", k));
        end

        // Enter another stall, then reset in the middle of it
        for (int k = 65; k <= 67; k++)
            cyc(1, 1'b0, mk(k - 65, (k - 65) >= 2, 1'b0, 1'b1, 1'b1), "rs_run");
        cyc(1, 1'b1, mk(3, 1'b1, 1'b0, 1'b1, 1'b1), "rs_enter");
        cyc(1, 1'b1, mk(3, 1'b1, 1'b0, 1'b1, 1'b1), "rs_stall1");
        cyc(1, 1'b1, mk(3, 1'b1, 1'b0, 1'b1, 1'b1), "rs_stall2");
        do_reset("midstall");
        run_tab4(1, "rerun");

        // DIV=2: alternating Phi2, strobe every 2nd clk, including across a stall
        do_reset("div2");
        for (int k = 0; k < 24; k++)
            cyc(2, tab2[k].wr, tab2[k].exp, $sformatf("div2_tab[%0d]", k + 1));
        cyc(2, 1'b0, mk(0, 1'b0, 1'b0, 1'b1, 1'b0), "div2_c25");
        cyc(2, 1'b1, mk(1, 1'b1, 1'b0, 1'b1, 1'b0), "div2_enter");
        cyc(2, 1'b0, mk(1, 1'b1, 1'b0, 1'b1, 1'b0), "div2_stall");
        cyc(2, 1'b0, mk(1, 1'b1, 1'b1, 1'b1, 1'b0), "div2_release");
        cyc(2, 1'b0, mk(0, 1'b0, 1'b0, 1'b1, 1'b0), "div2_after");
        cyc(2, 1'b0, mk(1, 1'b1, 1'b1, 1'b1, 1'b0), "div2_next");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
